imc_wb_ctrl: RTL and testbench



---
 rtl/imc_pkg.sv | 31 +++
 rtl/imc_cmp_seq.sv | 83 ++++++++
 rtl/imc_wb_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_imc_wb_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/imc_pkg.sv
// Shared types and constants for the IMC Wishbone controller.
package imc_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACC     = 2'd1,
    S_WAIT_RD = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  // Register offsets within the register region
  localparam logic [7:0] OFF_CTRL        = 8'h00;
  localparam logic [7:0] OFF_STATUS      = 8'h04;
  localparam logic [7:0] OFF_RESULT_BASE = 8'h10;

  // CTRL / STATUS bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_VCLP_BIT  = 1;
  localparam int CTRL_MASK_LSB  = 8;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;

  // Address bit that selects the register region over the array region
  localparam int REGION_BIT = 15;

  // RESULT slot index addressed by a register offset (negative below the base)
  function automatic int result_index(input logic [7:0] off);
    return int'(off[7:2]) - int'(OFF_RESULT_BASE[7:2]);
  endfunction

endpackage

// File: rtl/imc_cmp_seq.sv
// Compute sequencer: holds EN/EN_VCLP for CMP_CYCLES, then captures the
// masked banks' results in the following cycle and raises sticky DONE.
module imc_cmp_seq
  import imc_pkg::*;
#(
  parameter int DW         = 32,
  parameter int N_BANKS    = 4,
  parameter int CMP_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  launch,
  input  logic                  vclp_en,
  input  logic [N_BANKS-1:0]    bank_mask,
  input  logic                  done_clr,
  input  logic [N_BANKS*DW-1:0] mac_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  mac_en,
  output logic                  mac_en_vclp,
  output logic [N_BANKS-1:0]    bank_sel,
  output logic [N_BANKS*DW-1:0] results
);

  logic [7:0] cnt;
  logic       cap;

  // Compute timing: launch (ignored while busy), EN countdown, capture cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= 8'd0;
      cap         <= 1'b0;
      busy        <= 1'b0;
      mac_en      <= 1'b0;
      mac_en_vclp <= 1'b0;
      bank_sel    <= '0;
    end else if (launch && !busy) begin
      busy        <= 1'b1;
      mac_en      <= 1'b1;
      mac_en_vclp <= vclp_en;
      bank_sel    <= bank_mask;
      cnt         <= 8'(CMP_CYCLES - 1);
      cap         <= 1'b0;
    end else if (mac_en) begin
      if (cnt == 8'd0) begin
        mac_en      <= 1'b0;
        mac_en_vclp <= 1'b0;
        cap         <= 1'b1;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end else if (cap) begin
      cap      <= 1'b0;
      busy     <= 1'b0;
      bank_sel <= '0;
    end
  end

  // Sticky DONE: set at capture, W1C clear loses to a simultaneous set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
    end else if (cap) begin
      done <= 1'b1;
    end else if (done_clr) begin
      done <= 1'b0;
    end
  end

  // Per-bank result capture; unmasked banks keep their previous result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      results <= '0;
    end else begin
      for (int k = 0; k < N_BANKS; k++) begin
        if (cap && bank_sel[k]) begin
          results[k*DW +: DW] <= mac_rdata[k*DW +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/imc_wb_ctrl.sv
// Wishbone slave front-end for the IMC macro banks: array access FSM,
// CTRL/STATUS/RESULT register file, and the compute sequencer instance.
module imc_wb_ctrl
  import imc_pkg::*;
#(
  parameter int          DW         = 32,
  parameter int          ROW_AW     = 4,
  parameter int          N_BANKS    = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          RD_LAT     = 1,
  parameter int          CMP_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DW-1:0]         wbs_dat_i,
  output logic [DW-1:0]         wbs_dat_o,
  output logic                  wbs_ack_o,
  output logic [N_BANKS-1:0]    mac_bank_sel,
  output logic [ROW_AW-1:0]     mac_addr,
  output logic [DW-1:0]         mac_wdata,
  output logic [3:0]            mac_wmask,
  output logic                  mac_we,
  output logic                  mac_re,
  output logic                  mac_en,
  output logic                  mac_en_vclp,
  input  logic [N_BANKS*DW-1:0] mac_rdata
);

  localparam int BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

  state_t                  state, state_nxt;
  logic                    hit, req, is_reg, acc_reg, acc_we;
  logic [7:0]              off;
  logic [BW-1:0]           bank_dec, acc_bank;
  logic [N_BANKS-1:0]      acc_sel, seq_sel;
  logic [1:0]              rd_cnt;
  logic                    ctrl_vclp, vclp_eff;
  logic [7:0]              ctrl_mask, mask_eff;
  logic                    reg_wr, ctrl_wr, start, done_clr;
  logic                    busy, done;
  logic [N_BANKS*DW-1:0]   results;
  logic [DW-1:0]           reg_rdata, rd_val;
  int                      ridx;
  logic                    unused_adr;

  assign hit        = (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
  assign is_reg     = wbs_adr_i[REGION_BIT];
  assign off        = wbs_adr_i[7:0];
  assign req        = wbs_cyc_i & wbs_stb_i & hit;
  assign bank_dec   = (N_BANKS > 1) ? wbs_adr_i[2+ROW_AW +: BW] : '0;
  assign unused_adr = ^wbs_adr_i[14:8];
  // Array and compute never own the banks at the same time, so OR is safe
  assign mac_bank_sel = acc_sel | seq_sel;

  // Next-state: array accesses stall while computing, register accesses never do
  always_comb begin
    state_nxt = state;
    reg_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && (is_reg || !busy)) state_nxt = S_ACC;
        else                          state_nxt = S_IDLE;
      end
      S_ACC: begin
        if (!wbs_cyc_i) begin
          state_nxt = S_IDLE;
        end else if (!acc_reg && !acc_we) begin
          state_nxt = S_WAIT_RD;
        end else begin
          state_nxt = S_ACK;
          reg_wr    = acc_reg & acc_we;
        end
      end
      S_WAIT_RD: begin
        if (!wbs_cyc_i)                    state_nxt = S_IDLE;
        else if (rd_cnt == 2'(RD_LAT - 1)) state_nxt = S_ACK;
        else                               state_nxt = S_WAIT_RD;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Register write decode; a launching write uses its own VCLP/mask bytes
  always_comb begin
    ctrl_wr  = 1'b0;
    start    = 1'b0;
    done_clr = 1'b0;
    if (reg_wr) begin
      ctrl_wr  = (off == OFF_CTRL);
      start    = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[CTRL_START_BIT];
      done_clr = (off == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_DONE_BIT];
    end else begin
      ctrl_wr  = 1'b0;
    end
    if (ctrl_wr && wbs_sel_i[0]) vclp_eff = wbs_dat_i[CTRL_VCLP_BIT];
    else                         vclp_eff = ctrl_vclp;
    if (ctrl_wr && wbs_sel_i[1]) mask_eff = wbs_dat_i[CTRL_MASK_LSB +: 8];
    else                         mask_eff = ctrl_mask;
  end

  // Read data source: register mux in ACC, selected bank slice in WAIT_RD
  always_comb begin
    reg_rdata = '0;
    ridx      = result_index(off);
    if (acc_we) begin
      reg_rdata = '0;
    end else if (off == OFF_CTRL) begin
      reg_rdata = DW'({16'd0, ctrl_mask, 6'd0, ctrl_vclp, 1'b0});
    end else if (off == OFF_STATUS) begin
      reg_rdata = DW'({30'd0, done, busy});
    end else if (ridx >= 0 && ridx < N_BANKS && off[1:0] == 2'b00) begin
      reg_rdata = results[ridx*DW +: DW];
    end else begin
      reg_rdata = '0;
    end
    if (state == S_WAIT_RD) rd_val = mac_rdata[int'(acc_bank)*DW +: DW];
    else                    rd_val = reg_rdata;
  end

  // Bus-side state, ack/read-data pulse and macro access strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      acc_reg   <= 1'b0;
      acc_we    <= 1'b0;
      acc_bank  <= '0;
      acc_sel   <= '0;
      rd_cnt    <= 2'd0;
      mac_we    <= 1'b0;
      mac_re    <= 1'b0;
      mac_addr  <= '0;
      mac_wdata <= '0;
      mac_wmask <= 4'd0;
    end else begin
      state     <= state_nxt;
      wbs_ack_o <= (state_nxt == S_ACK);
      wbs_dat_o <= (state_nxt == S_ACK) ? rd_val : '0;
      rd_cnt    <= (state == S_WAIT_RD && state_nxt == S_WAIT_RD) ? rd_cnt + 2'd1 : 2'd0;
      mac_we    <= 1'b0;
      mac_re    <= 1'b0;
      mac_wmask <= 4'd0;
      if (state == S_IDLE && state_nxt == S_ACC) begin
        acc_reg <= is_reg;
        acc_we  <= wbs_we_i;
        if (!is_reg) begin
          mac_we    <= wbs_we_i;
          mac_re    <= !wbs_we_i;
          mac_addr  <= wbs_adr_i[2 +: ROW_AW];
          mac_wdata <= wbs_dat_i;
          mac_wmask <= wbs_we_i ? wbs_sel_i : 4'd0;
          acc_bank  <= bank_dec;
          acc_sel   <= N_BANKS'(1) << bank_dec;
        end
      end else if (state_nxt == S_ACK || state_nxt == S_IDLE) begin
        acc_sel <= '0;
      end
    end
  end

  // CTRL register: byte-lane writes of VCLP_EN and BANK_MASK
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_vclp <= 1'b0;
      ctrl_mask <= 8'd0;
    end else if (ctrl_wr) begin
      if (wbs_sel_i[0]) ctrl_vclp <= wbs_dat_i[CTRL_VCLP_BIT];
      if (wbs_sel_i[1]) ctrl_mask <= wbs_dat_i[CTRL_MASK_LSB +: 8];
    end
  end

  imc_cmp_seq #(
    .DW         (DW),
    .N_BANKS    (N_BANKS),
    .CMP_CYCLES (CMP_CYCLES)
  ) u_seq (
    .clk         (clk),
    .reset_n     (reset_n),
    .launch      (start),
    .vclp_en     (vclp_eff),
    .bank_mask   (mask_eff[N_BANKS-1:0]),
    .done_clr    (done_clr),
    .mac_rdata   (mac_rdata),
    .busy        (busy),
    .done        (done),
    .mac_en      (mac_en),
    .mac_en_vclp (mac_en_vclp),
    .bank_sel    (seq_sel),
    .results     (results)
  );

endmodule

// File: tb/tb_imc_wb_ctrl.sv
// Directed bench for imc_wb_ctrl with a behavioural 4-bank macro model.
module tb_imc_wb_ctrl;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]   sel = 4'd0;
  logic [31:0]  adr = 32'd0, wdat = 32'd0;
  logic [31:0]  rdat;
  logic         ack;
  logic [3:0]   bank_sel, maddr, mwmask;
  logic [31:0]  mwdata;
  logic         mwe, mre, men, mvclp;
  logic [127:0] mrdata;

  always #5 clk = ~clk;

  imc_wb_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(rdat), .wbs_ack_o(ack),
    .mac_bank_sel(bank_sel), .mac_addr(maddr), .mac_wdata(mwdata),
    .mac_wmask(mwmask), .mac_we(mwe), .mac_re(mre), .mac_en(men),
    .mac_en_vclp(mvclp), .mac_rdata(mrdata)
  );

  // Macro model: byte-masked RAM with 1-cycle read, compute returns cmp_base|bank
  logic [31:0] mem [4][16];
  logic [31:0] cmp_base = 32'd0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        mrdata[k*32 +: 32] <= 32'd0;
        for (int r = 0; r < 16; r++) mem[k][r] <= 32'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (bank_sel[k]) begin
          if (mwe)
            for (int b = 0; b < 4; b++)
              if (mwmask[b]) mem[k][maddr][b*8 +: 8] <= mwdata[b*8 +: 8];
          if (mre)      mrdata[k*32 +: 32] <= mem[k][maddr];
          else if (men) mrdata[k*32 +: 32] <= cmp_base | 32'(k);
        end
      end
    end
  end

  // Strobe monitor
  int we_cnt = 0, re_cnt = 0, en_cyc = 0, vclp_cyc = 0, re_in_en = 0;
  logic [3:0] we_sel = 4'd0, we_addr = 4'd0, we_mask = 4'd0, en_sel = 4'd0;
  always @(posedge clk) begin
    if (mwe) begin we_cnt++; we_sel = bank_sel; we_addr = maddr; we_mask = mwmask; end
    if (mre) begin re_cnt++; if (men) re_in_en++; end
    if (men) begin en_cyc++; en_sel = bank_sel; end
    if (mvclp) vclp_cyc++;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One classic transfer; lat = posedges from stb sampling to ack, 0 if none
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input int max_cyc,
                         output int lat, output logic [31:0] rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    lat = 0; rd = 32'd0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk); #1;
      if (ack) begin lat = i; rd = rdat; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    int          lat;
    logic [31:0] rd;
    logic        chk_we;
    logic [3:0]  esel, eaddr, emask;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  localparam logic [31:0] A_CTRL = 32'h3000_8000;
  localparam logic [31:0] A_STAT = 32'h3000_8004;
  localparam logic [31:0] A_RES  = 32'h3000_8010;

  int lat, w0, r0, e0, v0;
  logic [31:0] rd;
  logic done_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h3000_0094, 4'hF,    32'hDEAD_BEEF, 2, 32'h0,         1'b1, 4'b0100, 4'd5, 4'hF};
    vecs[1]  = '{1'b0, 32'h3000_0094, 4'hF,    32'h0,         3, 32'hDEAD_BEEF, 1'b0, 4'd0, 4'd0, 4'd0};
    vecs[2]  = '{1'b1, 32'h3000_004C, 4'b0010, 32'h1234_5A78, 2, 32'h0,         1'b1, 4'b0010, 4'd3, 4'b0010};
    vecs[3]  = '{1'b0, 32'h3000_004C, 4'hF,    32'h0,         3, 32'h0000_5A00, 1'b0, 4'd0, 4'd0, 4'd0};
    vecs[4]  = '{1'b0, 32'h3000_7F94, 4'hF,    32'h0,         3, 32'hDEAD_BEEF, 1'b0, 4'd0, 4'd0, 4'd0};
    vecs[5]  = '{1'b1, 32'h3000_0000, 4'hF,    32'h0000_0001, 2, 32'h0,         1'b1, 4'b0001, 4'd0, 4'hF};
    vecs[6]  = '{1'b0, 32'h3000_0000, 4'hF,    32'h0,         3, 32'h0000_0001, 1'b0, 4'd0, 4'd0, 4'd0};
    vecs[7]  = '{1'b1, 32'h3000_8040, 4'hF,    32'hFFFF_FFFF, 2, 32'h0,         1'b0, 4'd0, 4'd0, 4'd0};
    vecs[8]  = '{1'b0, 32'h3000_8040, 4'hF,    32'h0,         2, 32'h0,         1'b0, 4'd0, 4'd0, 4'd0};
    vecs[9]  = '{1'b0, A_CTRL,        4'hF,    32'h0,         2, 32'h0,         1'b0, 4'd0, 4'd0, 4'd0};
    vecs[10] = '{1'b0, A_STAT,        4'hF,    32'h0,         2, 32'h0,         1'b0, 4'd0, 4'd0, 4'd0};
    vecs[11] = '{1'b0, 32'h3001_0000, 4'hF,    32'h0,         0, 32'h0,         1'b0, 4'd0, 4'd0, 4'd0};
    vecs[12] = '{1'b1, 32'h3001_0094, 4'hF,    32'h5555_5555, 0, 32'h0,         1'b0, 4'd0, 4'd0, 4'd0};

    // Reset state
    #1;
    chk("reset_outputs", {rdat, 27'd0, ack, mwe, mre, men, mvclp}, 32'd0);
    chk("reset_bank_sel", {28'd0, bank_sel}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single transfers
    for (int i = 0; i < NV; i++) begin
      w0 = we_cnt; r0 = re_cnt;
      wb_xfer(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, 10, lat, rd);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      if (!vecs[i].w) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      if (vecs[i].chk_we) begin
        chk($sformatf("vec%0d_we_sel", i),  {28'd0, we_sel},  {28'd0, vecs[i].esel});
        chk($sformatf("vec%0d_we_addr", i), {28'd0, we_addr}, {28'd0, vecs[i].eaddr});
        chk($sformatf("vec%0d_we_mask", i), {28'd0, we_mask}, {28'd0, vecs[i].emask});
      end
      if (vecs[i].lat == 0) chk($sformatf("vec%0d_no_strobe", i), 32'(we_cnt - w0 + re_cnt - r0), 32'd0);
      chk($sformatf("vec%0d_dat_idle", i), rdat, 32'd0);
    end

    // Compute, all banks with clamp; STATUS and stalled array read during it
    cmp_base = 32'hA5A5_0000;
    e0 = en_cyc; v0 = vclp_cyc;
    wb_xfer(1'b1, A_CTRL, 4'b0011, 32'h0000_0F03, 10, lat, rd);
    chk("start_lat", lat, 2);
    wb_xfer(1'b0, A_STAT, 4'hF, 32'h0, 10, lat, rd);
    chk("status_busy_lat", lat, 2);
    chk("status_busy", rd, 32'h1);
    wb_xfer(1'b0, 32'h3000_0094, 4'hF, 32'h0, 20, lat, rd);
    chk("stalled_rd_lat_window", {31'd0, (lat >= 7 && lat <= 9)}, 32'd1);
    chk("stalled_rd_data", rd, 32'hDEAD_BEEF);
    chk("no_read_during_en", re_in_en, 0);
    chk("en_cycles", en_cyc - e0, 8);
    chk("vclp_cycles", vclp_cyc - v0, 8);
    chk("en_bank_sel", {28'd0, en_sel}, 32'hF);
    wb_xfer(1'b0, A_STAT, 4'hF, 32'h0, 10, lat, rd);
    chk("status_done", rd, 32'h2);
    for (int k = 0; k < 4; k++) begin
      wb_xfer(1'b0, A_RES + 32'(4*k), 4'hF, 32'h0, 10, lat, rd);
      chk($sformatf("result%0d", k), rd, 32'hA5A5_0000 | 32'(k));
    end
    wb_xfer(1'b0, A_RES + 32'd16, 4'hF, 32'h0, 10, lat, rd);
    chk("result_out_of_range", rd, 32'h0);
    wb_xfer(1'b0, A_CTRL, 4'hF, 32'h0, 10, lat, rd);
    chk("ctrl_readback", rd, 32'h0000_0F02);
    wb_xfer(1'b1, A_STAT, 4'b0001, 32'h0000_0002, 10, lat, rd);
    wb_xfer(1'b0, A_STAT, 4'hF, 32'h0, 10, lat, rd);
    chk("status_w1c", rd, 32'h0);

    // Partial-mask compute without clamp; a second START while busy is ignored
    cmp_base = 32'h1111_0000;
    e0 = en_cyc; v0 = vclp_cyc;
    wb_xfer(1'b1, A_CTRL, 4'b0011, 32'h0000_0501, 10, lat, rd);
    wb_xfer(1'b1, A_CTRL, 4'b0001, 32'h0000_0001, 10, lat, rd);
    chk("start_busy_ack", lat, 2);
    done_seen = 1'b0;
    for (int p = 0; p < 20 && !done_seen; p++) begin
      wb_xfer(1'b0, A_STAT, 4'hF, 32'h0, 10, lat, rd);
      if (rd[1]) done_seen = 1'b1;
    end
    chk("done_poll", {31'd0, done_seen}, 32'd1);
    chk("en_cycles_single_launch", en_cyc - e0, 8);
    chk("vclp_off", vclp_cyc - v0, 0);
    for (int k = 0; k < 4; k++) begin
      wb_xfer(1'b0, A_RES + 32'(4*k), 4'hF, 32'h0, 10, lat, rd);
      chk($sformatf("masked_result%0d", k), rd,
          ((k % 2) == 0) ? (32'h1111_0000 | 32'(k)) : (32'hA5A5_0000 | 32'(k)));
    end

    // Reset in the 4th compute cycle
    wb_xfer(1'b1, A_CTRL, 4'b0011, 32'h0000_0F03, 10, lat, rd);
    @(posedge clk); @(posedge clk); #2;
    chk("en_before_reset", {31'd0, men}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("en_async_drop", {30'd0, men, mvclp}, 32'd0);
    chk("bank_sel_reset", {28'd0, bank_sel}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("en_stays_low", {31'd0, men}, 32'd0);
    wb_xfer(1'b0, A_STAT, 4'hF, 32'h0, 10, lat, rd);
    chk("status_after_reset", rd, 32'h0);
    wb_xfer(1'b0, A_CTRL, 4'hF, 32'h0, 10, lat, rd);
    chk("ctrl_after_reset", rd, 32'h0);
    wb_xfer(1'b0, A_RES + 32'd4, 4'hF, 32'h0, 10, lat, rd);
    chk("result_after_reset", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
